// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Register-pending scoreboard and pipeline-control FSM for an in-order
// IF / ID / EX / ... / WB pipeline. The block tracks which architectural
// registers have an in-flight write, detects RAW and WAW hazards for the
// instruction in ID, and produces the stall / bubble / flush / issue controls
// for the front end. Taken branches and jumps resolved in EX flush the front
// end for the redirect cycle and one further cycle.
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous active-high reset
//   id_valid      in   1   ID stage holds a valid instruction
//   id_rs1_addr   in   5   source register 1 address (instr[19:15])
//   id_rs2_addr   in   5   source register 2 address (instr[24:20])
//   id_uses_rs1   in   1   instruction reads rs1
//   id_uses_rs2   in   1   instruction reads rs2
//   id_reg_write  in   1   instruction writes rd
//   id_rd_addr    in   5   destination register address
//   wb_reg_write  in   1   WB stage writes the register file this cycle
//   wb_rd_addr    in   5   WB destination register address
//   ex_redirect   in   1   taken branch / jump resolved in EX this cycle
//   stall_if_id   out  1   hold PC and IF/ID register
//   bubble_ex     out  1   load a NOP into ID/EX
//   flush_if_id   out  1   clear IF/ID register
//   issue         out  1   ID instruction advances to EX this cycle
//   busy_mask     out  32  registered pending-write bits (bit 0 always 0)
//   state         out  2   FSM state: RUN=0, STALL=1, FLUSH=2
//   stall_count   out  16  saturating count of hazard-stall cycles

module hazard_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_reg_write,
    input  logic [4:0]  id_rd_addr,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic        ex_redirect,
    output logic        stall_if_id,
    output logic        bubble_ex,
    output logic        flush_if_id,
    output logic        issue,
    output logic [31:0] busy_mask,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:1] pending_q;
    logic [31:1] pending_d;
    logic [31:0] pending_full;
    logic [15:0] stall_count_q;
    logic        hazard;
    logic        kill;
    logic        wb_clear;
    logic        id_set;

    // x0 is never pending, so bit 0 is tied off rather than stored.
    assign pending_full = {pending_q, 1'b0};

    // A pending register stops being busy in the cycle WB writes it, because
    // the register file forwards a same-cycle write to the ID read ports.
    function automatic logic src_busy(input logic [31:0] pend,
                                      input logic        wb_we,
                                      input logic [4:0]  wb_rd,
                                      input logic [4:0]  a);
        return pend[a] && !(wb_we && (wb_rd == a) && (a != 5'd0));
    endfunction

    // Hazard detection: RAW on either source, plus WAW on rd so that two
    // writes to the same register can never be in flight at once.
    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            hazard = (id_uses_rs1  && src_busy(pending_full, wb_reg_write, wb_rd_addr, id_rs1_addr)) ||
                     (id_uses_rs2  && src_busy(pending_full, wb_reg_write, wb_rd_addr, id_rs2_addr)) ||
                     (id_reg_write && src_busy(pending_full, wb_reg_write, wb_rd_addr, id_rd_addr));
        end
    end

    // A redirect (or the cycle after it) kills whatever sits in ID; kill
    // outranks the hazard so a killed instruction neither stalls nor issues.
    assign kill        = ex_redirect || (state_q == FLUSH);
    assign flush_if_id = kill;
    assign bubble_ex   = kill || hazard;
    assign stall_if_id = hazard && !kill;
    assign issue       = id_valid && !hazard && !kill;

    assign wb_clear = wb_reg_write && (wb_rd_addr != 5'd0);
    assign id_set   = issue && id_reg_write && (id_rd_addr != 5'd0);

    // Scoreboard update: clear first, then set, so that an issuing writer
    // of the register WB is retiring leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_clear) begin
            pending_d[wb_rd_addr] = 1'b0;
        end
        if (id_set) begin
            pending_d[id_rd_addr] = 1'b1;
        end
    end

    // Next-state logic. A redirect always enters FLUSH; otherwise every
    // state goes to STALL while a hazard is present and to RUN when not.
    always_comb begin
        state_d = state_q;
        if (ex_redirect) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                RUN:     state_d = hazard ? STALL : RUN;
                STALL:   state_d = hazard ? STALL : RUN;
                FLUSH:   state_d = hazard ? STALL : RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pending_q     <= '0;
            stall_count_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (stall_if_id && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign busy_mask   = pending_full;
    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. Each step drives one cycle of
// stimulus shortly after a rising edge, pushes the hand-derived expected
// outputs for that cycle into a queue, and pops/compares them at the
// following falling edge. Registered outputs in an expectation are the
// values held before the edge that ends the step.

module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_reg_write;
    logic [4:0]  id_rd_addr;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic        ex_redirect;
    logic        stall_if_id;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        issue;
    logic [31:0] busy_mask;
    logic [1:0]  state;
    logic [15:0] stall_count;

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_reg_write (id_reg_write),
        .id_rd_addr   (id_rd_addr),
        .wb_reg_write (wb_reg_write),
        .wb_rd_addr   (wb_rd_addr),
        .ex_redirect  (ex_redirect),
        .stall_if_id  (stall_if_id),
        .bubble_ex    (bubble_ex),
        .flush_if_id  (flush_if_id),
        .issue        (issue),
        .busy_mask    (busy_mask),
        .state        (state),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       reset;
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       reg_write;
        logic [4:0] rd;
        logic       wb_we;
        logic [4:0] wb_rd;
        logic       redirect;
    } stim_t;

    typedef struct {
        string       tag;
        logic        stall;
        logic        bubble;
        logic        flush;
        logic        issue;
        logic [31:0] mask;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    function automatic stim_t idle();
        stim_t s;
        s.reset     = 1'b0;
        s.id_valid  = 1'b0;
        s.rs1       = 5'd0;
        s.rs2       = 5'd0;
        s.uses_rs1  = 1'b0;
        s.uses_rs2  = 1'b0;
        s.reg_write = 1'b0;
        s.rd        = 5'd0;
        s.wb_we     = 1'b0;
        s.wb_rd     = 5'd0;
        s.redirect  = 1'b0;
        return s;
    endfunction

    function automatic exp_t mk(input string tag, input logic stall, input logic bubble,
                                input logic flush, input logic iss, input logic [31:0] mask,
                                input logic [1:0] st, input logic [15:0] cnt);
        exp_t e;
        e.tag    = tag;
        e.stall  = stall;
        e.bubble = bubble;
        e.flush  = flush;
        e.issue  = iss;
        e.mask   = mask;
        e.st     = st;
        e.cnt    = cnt;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        reset        = s.reset;
        id_valid     = s.id_valid;
        id_rs1_addr  = s.rs1;
        id_rs2_addr  = s.rs2;
        id_uses_rs1  = s.uses_rs1;
        id_uses_rs2  = s.uses_rs2;
        id_reg_write = s.reg_write;
        id_rd_addr   = s.rd;
        wb_reg_write = s.wb_we;
        wb_rd_addr   = s.wb_rd;
        ex_redirect  = s.redirect;
    endtask

    task automatic compare(input string tag, input string field,
                           input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expq.size() == 0) begin
            checks_total++;
            $error("[TB] FAIL scoreboard_underflow observed=empty expected=entry");
            return;
        end
        e = expq.pop_front();
        compare(e.tag, "stall_if_id", {31'd0, stall_if_id}, {31'd0, e.stall});
        compare(e.tag, "bubble_ex",   {31'd0, bubble_ex},   {31'd0, e.bubble});
        compare(e.tag, "flush_if_id", {31'd0, flush_if_id}, {31'd0, e.flush});
        compare(e.tag, "issue",       {31'd0, issue},       {31'd0, e.issue});
        compare(e.tag, "busy_mask",   busy_mask,            e.mask);
        compare(e.tag, "state",       {30'd0, state},       {30'd0, e.st});
        compare(e.tag, "stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
    endtask

    // One cycle: drive after the rising edge, record the expectation, and
    // compare at the falling edge when chk is set.
    task automatic applyStimulus(input stim_t s, input exp_t e, input bit chk);
        @(posedge clk);
        #1;
        drive(s);
        if (chk) expq.push_back(e);
        @(negedge clk);
        if (chk) checkOutput();
    endtask

    initial begin
        stim_t s;
        exp_t  none;
        none = mk("none", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 16'd0);

        s = idle();
        s.reset = 1'b1;
        drive(s);

        // Reset state.
        applyStimulus(s, mk("rst", 0, 0, 0, 0, 32'h0, 2'd0, 16'd0), 1);
        // Reset dominates redirect; kill still shows combinationally.
        s = idle(); s.reset = 1'b1; s.redirect = 1'b1;
        s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'd4;
        applyStimulus(s, mk("rst_redirect", 0, 1, 1, 0, 32'h0, 2'd0, 16'd0), 1);
        // Issue under reset: comb issue, but no set may land.
        s = idle(); s.reset = 1'b1;
        s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'd4;
        applyStimulus(s, mk("rst_issue", 0, 0, 0, 1, 32'h0, 2'd0, 16'd0), 1);

        // ADD x5, x1, x2.
        s = idle(); s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'd5;
        s.uses_rs1 = 1'b1; s.rs1 = 5'd1; s.uses_rs2 = 1'b1; s.rs2 = 5'd2;
        applyStimulus(s, mk("add_x5", 0, 0, 0, 1, 32'h0, 2'd0, 16'd0), 1);

        // Dependent on x5, writes x6: stalls for three cycles.
        s = idle(); s.id_valid = 1'b1; s.uses_rs1 = 1'b1; s.rs1 = 5'd5;
        s.reg_write = 1'b1; s.rd = 5'd6;
        applyStimulus(s, mk("raw_c0", 1, 1, 0, 0, 32'h20, 2'd0, 16'd0), 1);
        applyStimulus(s, mk("raw_c1", 1, 1, 0, 0, 32'h20, 2'd1, 16'd1), 1);
        applyStimulus(s, mk("raw_c2", 1, 1, 0, 0, 32'h20, 2'd1, 16'd2), 1);
        // WB writes x5: bypass releases the stall in the same cycle.
        s.wb_we = 1'b1; s.wb_rd = 5'd5;
        applyStimulus(s, mk("raw_wb", 0, 0, 0, 1, 32'h20, 2'd1, 16'd3), 1);
        s = idle();
        applyStimulus(s, mk("raw_done", 0, 0, 0, 0, 32'h40, 2'd0, 16'd3), 1);

        // Set wins over clear on x7.
        s = idle(); s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'd7;
        applyStimulus(s, mk("wr_x7", 0, 0, 0, 1, 32'h40, 2'd0, 16'd3), 1);
        s.wb_we = 1'b1; s.wb_rd = 5'd7;
        applyStimulus(s, mk("wr_x7_wb", 0, 0, 0, 1, 32'hC0, 2'd0, 16'd3), 1);
        s = idle();
        applyStimulus(s, mk("set_wins", 0, 0, 0, 0, 32'hC0, 2'd0, 16'd3), 1);

        // WAW on x6, then redirect coincident with the hazard.
        s = idle(); s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'd6;
        applyStimulus(s, mk("waw_x6", 1, 1, 0, 0, 32'hC0, 2'd0, 16'd3), 1);
        s.redirect = 1'b1;
        applyStimulus(s, mk("redir_haz", 0, 1, 1, 0, 32'hC0, 2'd1, 16'd4), 1);
        s = idle();
        applyStimulus(s, mk("flush_cyc", 0, 1, 1, 0, 32'hC0, 2'd2, 16'd4), 1);

        // Redirect kills an otherwise-issuable writer of x9.
        s = idle(); s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'd9; s.redirect = 1'b1;
        applyStimulus(s, mk("redir_kill", 0, 1, 1, 0, 32'hC0, 2'd0, 16'd4), 1);
        s = idle();
        applyStimulus(s, mk("flush_cyc2", 0, 1, 1, 0, 32'hC0, 2'd2, 16'd4), 1);

        // Retire x6 and x7.
        s = idle(); s.wb_we = 1'b1; s.wb_rd = 5'd6;
        applyStimulus(s, mk("wb_x6", 0, 0, 0, 0, 32'hC0, 2'd0, 16'd4), 1);
        s = idle(); s.wb_we = 1'b1; s.wb_rd = 5'd7;
        applyStimulus(s, mk("wb_x7", 0, 0, 0, 0, 32'h80, 2'd0, 16'd4), 1);

        // x0 as source and destination never stalls or sets.
        s = idle(); s.id_valid = 1'b1; s.uses_rs1 = 1'b1; s.rs1 = 5'd0;
        s.reg_write = 1'b1; s.rd = 5'd0; s.wb_we = 1'b1; s.wb_rd = 5'd0;
        applyStimulus(s, mk("x0_a", 0, 0, 0, 1, 32'h0, 2'd0, 16'd4), 1);
        applyStimulus(s, mk("x0_b", 0, 0, 0, 1, 32'h0, 2'd0, 16'd4), 1);

        // Make x3 pending, then show id_valid=0 produces no hazard.
        s = idle(); s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'd3;
        applyStimulus(s, mk("wr_x3", 0, 0, 0, 1, 32'h0, 2'd0, 16'd4), 1);
        s = idle(); s.uses_rs1 = 1'b1; s.rs1 = 5'd3; s.reg_write = 1'b1; s.rd = 5'd3;
        applyStimulus(s, mk("invalid", 0, 0, 0, 0, 32'h8, 2'd0, 16'd4), 1);

        // Hold a hazard on x3 long enough to saturate the stall counter.
        s.id_valid = 1'b1;
        applyStimulus(s, mk("sat_start", 1, 1, 0, 0, 32'h8, 2'd0, 16'd4), 1);
        repeat (70000) @(posedge clk);
        applyStimulus(s, mk("sat_full", 1, 1, 0, 0, 32'h8, 2'd1, 16'hFFFF), 1);
        applyStimulus(s, mk("sat_hold", 1, 1, 0, 0, 32'h8, 2'd1, 16'hFFFF), 1);

        // Fill every register except x3 (already pending).
        for (int i = 1; i < 32; i++) begin
            if (i != 3) begin
                s = idle(); s.id_valid = 1'b1; s.reg_write = 1'b1; s.rd = 5'(i);
                applyStimulus(s, none, 0);
            end
        end

        // Stall on x1 with a full scoreboard, then reset.
        s = idle(); s.id_valid = 1'b1; s.uses_rs1 = 1'b1; s.rs1 = 5'd1;
        applyStimulus(s, mk("full_stall", 1, 1, 0, 0, 32'hFFFF_FFFE, 2'd0, 16'hFFFF), 1);
        s.reset = 1'b1;
        applyStimulus(s, mk("full_rst", 1, 1, 0, 0, 32'hFFFF_FFFE, 2'd1, 16'hFFFF), 1);
        s = idle();
        applyStimulus(s, mk("after_rst", 0, 0, 0, 0, 32'h0, 2'd0, 16'd0), 1);

        checks_total++;
        assert (expq.size() == 0) checks_passed++;
        else $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expq.size());

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-002 id_valid  input  1  ID stage holds a valid instruction.
REQ-003 id_rs1_addr, id_rs2_addr  input  5 each  source register addresses (instr[19:15], instr[24:20]).
REQ-004 id_uses_rs1, id_uses_rs2  input  1 each  the instruction reads that source.
REQ-005 id_reg_write  input  1  the instruction writes rd.
REQ-006 id_rd_addr  input  5  destination register address.
REQ-007 wb_reg_write  input  1  WB stage writes the register file this cycle.
REQ-008 wb_rd_addr  input  5  WB destination register address.
REQ-009 ex_redirect  input  1  taken branch or jump resolved in EX this cycle.
REQ-010 stall_if_id  output  1  hold PC and IF/ID register.
REQ-011 bubble_ex  output  1  load a NOP into ID/EX.
REQ-012 flush_if_id  output  1  clear IF/ID register.
REQ-013 issue  output  1  the ID instruction advances to EX this cycle.
REQ-014 busy_mask  output  32  registered pending-write bits; bit 0 always 0.
REQ-015 state  output  2  FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-016 stall_count  output  16  saturating count of hazard-stall cycles.

Function
REQ-017 Scoreboard: pending[31:1] SHALL be registered; pending[0] SHALL be constant 0.
REQ-018 src_busy(a) SHALL be pending[a] && !(wb_reg_write && wb_rd_addr==a && a!=0), because the register file write is visible to same-cycle reads.
REQ-019 hazard SHALL be id_valid && ((id_uses_rs1 && src_busy(rs1)) || (id_uses_rs2 && src_busy(rs2)) || (id_reg_write && src_busy(rd))); the rd term prevents WAW.
REQ-020 kill SHALL be ex_redirect || (state==FLUSH).
REQ-021 Outputs SHALL be combinational in the current cycle:
  - flush_if_id = kill
  - bubble_ex = kill || hazard
  - stall_if_id = hazard && !kill
  - issue = id_valid && !hazard && !kill
REQ-022 Clear: when wb_reg_write && wb_rd_addr!=0, pending[wb_rd_addr] SHALL be cleared at the next edge.
REQ-023 Set: when issue && id_reg_write && id_rd_addr!=0, pending[id_rd_addr] SHALL be set at the next edge.
REQ-024 When set and clear target the same register in the same cycle, set SHALL win.
REQ-025 FSM next state:
  - ex_redirect -> FLUSH, from any state.
  - FLUSH -> RUN or STALL on the following cycle, chosen by hazard; FLUSH SHALL last exactly 1 cycle unless ex_redirect is asserted again.
  - RUN -> STALL when hazard.
  - STALL -> RUN when !hazard.
REQ-026 stall_count SHALL increment when stall_if_id==1 and SHALL hold at 16'hFFFF.
REQ-027 ex_redirect SHALL take priority over hazard: a killed instruction SHALL NOT set pending and SHALL NOT count as a stall.
REQ-028 An instruction with id_valid==0 SHALL produce no hazard, no issue and no set.

Reset
REQ-029 On reset, the following SHALL apply at the next edge: pending=0, busy_mask=0, state=RUN, stall_count=0.
REQ-030 While reset is high, no set or clear SHALL take effect.
REQ-031 Reset SHALL dominate ex_redirect and all other inputs.
REQ-032 Combinational outputs SHALL follow REQ-021 using the reset register values.

Verification
REQ-033 Issue ADD x5 (reg_write, rd=5) -> issue=1; next cycle busy_mask=32'h20. Then a dependent instruction with rs1=5 -> stall_if_id=1, bubble_ex=1, issue=0, state=STALL, and stall_count increments each cycle.
REQ-034 While stalled on x5, apply wb_reg_write=1, wb_rd_addr=5 -> same cycle hazard=0, issue=1; next cycle state=RUN and busy_mask bit5=0.
REQ-035 In the same cycle, wb clears x7 and an issuing instruction writes x7 -> busy_mask bit7=1 on the next cycle.
REQ-036 ex_redirect=1 coincident with a hazard:
  - Redirect cycle: flush_if_id=1, bubble_ex=1, stall_if_id=0, issue=0.
  - Next cycle: state=FLUSH, flush_if_id=1.
  - Cycle after: state=RUN.
  - stall_count is unchanged throughout.
REQ-037 Instruction with rd=x0 and rs1=x0 -> never stalls and busy_mask stays 0. Holding a hazard for 70000 cycles -> stall_count=16'hFFFF.
REQ-038 Assert reset with busy_mask=32'hFFFF_FFFE and state=STALL -> next cycle busy_mask=0, state=RUN, stall_count=0.
